// File: rtl/riscv_pkg.sv
// Shared types and constants for the execute-to-memory pipeline stage.
// The optional forwarding outputs of ex_mem_stage are enabled by the macro EX_MEM_FWD_EN.
package riscv_pkg;

  // Datapath width used by the packed payload struct.
  localparam int XLEN_P = 32;

  // Conditional branch funct3 encodings.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Payload carried from execute to the memory stage.
  typedef struct packed {
    logic [XLEN_P-1:0] result;
    logic [XLEN_P-1:0] store_data;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_mem_t;

  // Branch decision from the ALU zero flag. Execute issues SUB for BEQ/BNE
  // and SLT/SLTU for the ordered compares, so funct3 bits 0 and 2 select the
  // polarity. The reserved encodings 010/011 never take.
  function automatic logic branch_taken(input logic zero, input logic [2:0] f3);
    logic legal;
    legal = (f3 != 3'b010) && (f3 != 3'b011);
    return legal && (zero ^ f3[0] ^ f3[2]);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry catches one payload while the output is stalled, so in_ready_o
// is a pure register output with no combinational path from out_ready_i.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         main_free;

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

  assign accept    = in_valid_i && !skid_valid_q && !flush_i;
  assign main_free = !main_valid_q || out_ready_i;

  // Next-state for both entries; data fields hold unless loaded so the
  // output data keeps its last value while out_valid_o is low.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Skid full implies in_ready_o=0, so nothing is accepted this cycle.
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_data_i;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data_i;
    end
  end

  // Entry registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage: registers the ALU result and control
// metadata through a two-entry skid buffer and resolves conditional branches
// into a one-cycle redirect pulse. Define EX_MEM_FWD_EN to add the bypass
// outputs fwd_valid_o / fwd_rd_o / fwd_data_o driven from the main entry.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32  // must match riscv_pkg::XLEN_P
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            branch_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output logic [XLEN-1:0] out_store_data_o,
  output logic [4:0]      out_rd_o,
  output logic [2:0]      out_funct3_o,
  output logic            out_reg_write_o,
  output logic            out_mem_read_o,
  output logic            out_mem_write_o,
`ifdef EX_MEM_FWD_EN
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_rd_o,
  output logic [XLEN-1:0] fwd_data_o,
`endif
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  ex_mem_t         in_pl;
  ex_mem_t         out_pl;
  logic            accept;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  assign in_pl.result     = alu_result_i;
  assign in_pl.store_data = rs2_data_i;
  assign in_pl.rd         = rd_i;
  assign in_pl.funct3     = funct3_i;
  assign in_pl.reg_write  = reg_write_i;
  assign in_pl.mem_read   = mem_read_i;
  assign in_pl.mem_write  = mem_write_i;

  pipe_skid_buf #(
    .W ($bits(ex_mem_t))
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_pl)
  );

  assign out_result_o     = out_pl.result;
  assign out_store_data_o = out_pl.store_data;
  assign out_rd_o         = out_pl.rd;
  assign out_funct3_o     = out_pl.funct3;
  assign out_reg_write_o  = out_pl.reg_write;
  assign out_mem_read_o   = out_pl.mem_read;
  assign out_mem_write_o  = out_pl.mem_write;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid_o = out_valid_o && out_pl.reg_write && (out_pl.rd != 5'd0);
  assign fwd_rd_o    = out_pl.rd;
  assign fwd_data_o  = out_pl.result;
`endif

  // Flush blocks acceptance, which also suppresses a same-cycle redirect.
  assign accept = in_valid_i && in_ready_o && !flush_i;

  // Redirect pulses for one cycle after a taken branch is accepted; the
  // target register holds its last value between pulses.
  always_comb begin
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (accept && branch_i && branch_taken(alu_zero_i, funct3_i)) begin
      redirect_d    = 1'b1;
      redirect_pc_d = pc_target_i;
    end
  end

  // Redirect registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage with hand-computed expectations.
// Forwarding checks are compiled in when EX_MEM_FWD_EN is defined.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic [31:0] rs2_data_i;
  logic [31:0] pc_target_i;
  logic [4:0]  rd_i;
  logic        reg_write_i, mem_read_i, mem_write_i, branch_i;
  logic [2:0]  funct3_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o, out_store_data_o;
  logic [4:0]  out_rd_o;
  logic [2:0]  out_funct3_o;
  logic        out_reg_write_o, out_mem_read_o, out_mem_write_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rs2_data_i(rs2_data_i), .pc_target_i(pc_target_i), .rd_i(rd_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .branch_i(branch_i), .funct3_i(funct3_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_store_data_o(out_store_data_o),
    .out_rd_o(out_rd_o), .out_funct3_o(out_funct3_o),
    .out_reg_write_o(out_reg_write_o), .out_mem_read_o(out_mem_read_o),
    .out_mem_write_o(out_mem_write_o),
`ifdef EX_MEM_FWD_EN
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
`endif
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                       input logic br, input logic [2:0] f3, input logic z,
                       input logic [31:0] tgt);
    in_valid_i   = 1'b1;
    alu_result_i = res;
    rs2_data_i   = res ^ 32'hFFFF_0000;
    rd_i         = rd;
    reg_write_i  = rw;
    branch_i     = br;
    funct3_i     = f3;
    alu_zero_i   = z;
    pc_target_i  = tgt;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    branch_i   = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; in_valid_i = 0; alu_result_i = 0; alu_zero_i = 0;
    rs2_data_i = 0; pc_target_i = 0; rd_i = 0; reg_write_i = 0;
    mem_read_i = 0; mem_write_i = 0; branch_i = 0; funct3_i = 0;
    flush_i = 0; out_ready_i = 1;
    #12;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_result", out_result_o, 0);
    chk("rst_rd", out_rd_o, 0);
    rst_i = 1'b0;

    // Streaming 5, 7, 9 with out_ready high.
    offer(32'd5, 5'd1, 1, 0, 3'b000, 0, 0);
    step(); chk("s0_valid", out_valid_o, 1); chk("s0_res", out_result_o, 5);
    chk("s0_rdy", in_ready_o, 1);
    offer(32'd7, 5'd2, 1, 0, 3'b000, 0, 0);
    step(); chk("s1_res", out_result_o, 7); chk("s1_rdy", in_ready_o, 1);
    offer(32'd9, 5'd3, 1, 0, 3'b000, 0, 0);
    step(); chk("s2_res", out_result_o, 9); chk("s2_rd", out_rd_o, 3);
    chk("s2_store", out_store_data_o, 32'hFFFF_0009);
    idle();
    step(); chk("s3_valid", out_valid_o, 0); chk("s3_hold", out_result_o, 9);

    // Backpressure: A into main, B into skid, ready drops.
    out_ready_i = 0;
    offer(32'h11, 5'd4, 1, 0, 3'b000, 0, 0);
    step(); chk("bp_a_valid", out_valid_o, 1); chk("bp_a_res", out_result_o, 32'h11);
    chk("bp_a_rdy", in_ready_o, 1);
    offer(32'h22, 5'd5, 1, 0, 3'b000, 0, 0);
    step(); chk("bp_b_rdy", in_ready_o, 0); chk("bp_b_res", out_result_o, 32'h11);
    idle();
    step(); chk("bp_c_rdy", in_ready_o, 0); chk("bp_c_res", out_result_o, 32'h11);
    out_ready_i = 1;
    step(); chk("bp_d_valid", out_valid_o, 1); chk("bp_d_res", out_result_o, 32'h22);
    chk("bp_d_rdy", in_ready_o, 1);
    step(); chk("bp_e_valid", out_valid_o, 0);

    // BEQ taken on zero.
    offer(32'h0, 5'd0, 0, 1, 3'b000, 1, 32'h100);
    step(); chk("beq_redir", redirect_o, 1); chk("beq_pc", redirect_pc_o, 32'h100);
    chk("beq_valid", out_valid_o, 1); chk("beq_rw", out_reg_write_o, 0);
    idle();
    step(); chk("beq_pulse_end", redirect_o, 0);
    // BGE with zero=0: not taken.
    offer(32'h1, 5'd0, 0, 1, 3'b101, 0, 32'h200);
    step(); chk("bge_redir", redirect_o, 0); chk("bge_valid", out_valid_o, 1);
    // BLTU with zero=0: taken.
    offer(32'h1, 5'd0, 0, 1, 3'b110, 0, 32'h300);
    step(); chk("bltu_redir", redirect_o, 1); chk("bltu_pc", redirect_pc_o, 32'h300);
    chk("bltu_f3", out_funct3_o, 3'b110);
    // BNE with zero=1: not taken.
    offer(32'h0, 5'd0, 0, 1, 3'b001, 1, 32'h340);
    step(); chk("bne_redir", redirect_o, 0);
    // Reserved funct3 010 with zero=1: never taken.
    offer(32'h0, 5'd0, 0, 1, 3'b010, 1, 32'h380);
    step(); chk("f3_010_redir", redirect_o, 0);
    // Non-branch with a taking-looking zero flag: no redirect.
    offer(32'h0, 5'd6, 1, 0, 3'b000, 1, 32'h3C0);
    step(); chk("nobr_redir", redirect_o, 0);
    idle();
    step();

    // Skid full, then flush with a taken branch offered.
    out_ready_i = 0;
    offer(32'h41, 5'd7, 1, 0, 3'b000, 0, 0);
    step();
    offer(32'h42, 5'd8, 1, 0, 3'b000, 0, 0);
    step(); chk("fl_full_rdy", in_ready_o, 0);
    offer(32'h43, 5'd0, 0, 1, 3'b000, 1, 32'h400);
    flush_i = 1;
    step(); chk("fl_valid", out_valid_o, 0); chk("fl_rdy", in_ready_o, 1);
    chk("fl_redir", redirect_o, 0);
    // Flush with only main occupied and a taken branch acceptable otherwise.
    flush_i = 0;
    offer(32'h44, 5'd9, 1, 0, 3'b000, 0, 0);
    step(); chk("fl2_valid_pre", out_valid_o, 1);
    offer(32'h45, 5'd0, 0, 1, 3'b000, 1, 32'h480);
    flush_i = 1;
    step(); chk("fl2_valid", out_valid_o, 0); chk("fl2_redir", redirect_o, 0);
    flush_i = 0;
    idle();
    step(); chk("fl2_redir_after", redirect_o, 0); chk("fl2_valid_after", out_valid_o, 0);

    // Asynchronous reset while holding two entries and a live redirect.
    offer(32'h51, 5'd10, 1, 0, 3'b000, 0, 0);
    step();
    offer(32'h52, 5'd0, 0, 1, 3'b000, 1, 32'h500);
    step(); chk("ar_redir_pre", redirect_o, 1); chk("ar_rdy_pre", in_ready_o, 0);
    idle();
    #2 rst_i = 1'b1;
    #1;
    chk("ar_valid", out_valid_o, 0); chk("ar_rdy", in_ready_o, 1);
    chk("ar_result", out_result_o, 0); chk("ar_redir", redirect_o, 0);
    chk("ar_redir_pc", redirect_pc_o, 0);
    #2 rst_i = 1'b0;
    out_ready_i = 1;
    offer(32'h33, 5'd11, 1, 0, 3'b000, 0, 0);
    step(); chk("ar_post_res", out_result_o, 32'h33); chk("ar_post_valid", out_valid_o, 1);
    idle();
    step();

`ifdef EX_MEM_FWD_EN
    offer(32'h2A, 5'd5, 1, 0, 3'b000, 0, 0);
    step(); chk("fwd_valid", fwd_valid_o, 1); chk("fwd_rd", fwd_rd_o, 5);
    chk("fwd_data", fwd_data_o, 32'h2A);
    offer(32'h2B, 5'd0, 1, 0, 3'b000, 0, 0);
    step(); chk("fwd_x0", fwd_valid_o, 0);
    idle();
    step(); chk("fwd_idle", fwd_valid_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the RISC-V core. It registers the ALU's `result_o`/`zero_o` together with the instruction's control metadata and store data, and resolves conditional branches from the ALU zero flag. It drives a one-cycle redirect to fetch and presents a valid/ready stream to the memory stage. A two-entry skid buffer absorbs memory-stage backpressure without a combinational ready path back into execute.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_valid_i` in 1: execute-stage payload valid.
- `in_ready_o` out 1: stage can accept; registered, equals NOT skid-entry-valid.
- `alu_result_i` in XLEN: ALU `result_o`.
- `alu_zero_i` in 1: ALU `zero_o`.
- `rs2_data_i` in XLEN: store data.
- `pc_target_i` in XLEN: branch target address.
- `rd_i` in 5: destination register.
- `reg_write_i`, `mem_read_i`, `mem_write_i`, `branch_i` in 1 each: control bits.
- `funct3_i` in 3: instruction funct3.
- `flush_i` in 1: kill all held and incoming payloads.
- `out_valid_o` out 1, `out_ready_i` in 1: memory-stage handshake.
- `out_result_o`, `out_store_data_o` out XLEN; `out_rd_o` out 5; `out_funct3_o` out 3; `out_reg_write_o`, `out_mem_read_o`, `out_mem_write_o` out 1.
- `redirect_o` out 1: taken-branch pulse.
- `redirect_pc_o` out XLEN: redirect target.

## Operation
- Accept when `in_valid_i && in_ready_o && !flush_i`. Transfer out when `out_valid_o && out_ready_i`.
- Storage: main entry (drives outputs) and skid entry. Per-cycle behaviour:
  - Main empty or transferring: the skid entry, if valid, moves to main; otherwise the accepted payload loads into main.
  - Main stalled: an accepted payload loads into skid.
  - The skid can only fill while `in_ready_o`=1, so it never overflows.
- Branch resolution applies to an accepted payload with `branch_i`=1: taken = `alu_zero_i ^ funct3_i[0] ^ funct3_i[2]`.
  - BEQ is taken on zero, BNE on nonzero, BLT/BLTU on nonzero, BGE/BGEU on zero. Execute issues SUB for BEQ/BNE and SLT/SLTU (ctrl 1001/1000) for the compares.
  - funct3 010 and 011 are never taken.
- Taken branch: `redirect_o`=1 and `redirect_pc_o`=`pc_target_i` in the cycle after acceptance, for exactly one cycle. The branch payload still flows downstream with its own control bits (reg_write=0).
- Flush: both entries are invalidated at the clock edge and the same-cycle input is not accepted. A redirect for a branch offered in the flush cycle is suppressed. A redirect already registered is not retracted.
- Output data fields hold their last value when `out_valid_o`=0. Only valid is cleared.

## Timing
- Latency is 1 cycle from acceptance to `out_valid_o`. Throughput is 1 per cycle with `out_ready_i` held high.
- `in_ready_o` falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Reset values: `out_valid_o`=0, `redirect_o`=0, all data and control outputs 0, `redirect_pc_o`=0, `in_ready_o`=1.
- Reset asserted mid-stream discards both entries immediately (asynchronous) with no redirect.
- Flush and reset both clear state; reset dominates.

## Configuration
- Macro: `EX_MEM_FWD_EN`.
- Defined: adds outputs `fwd_valid_o` (1), `fwd_rd_o` (5) and `fwd_data_o` (XLEN), driven from the main entry. `fwd_valid_o` = main valid AND `reg_write` AND `rd`≠0, for execute-stage bypass.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- `riscv_pkg` holds the branch funct3 constants (`F3_BEQ` … `F3_BGEU`) and the packed payload struct `ex_mem_t` (result, store data, rd, funct3, control bits).
- One sub-module, `pipe_skid_buf`, is a generic two-entry valid/ready skid buffer parameterised on payload width. The stage instantiates it with `$bits(ex_mem_t)` and adds the branch/redirect logic around it.

## Test plan
- Stream three ALU results 5, 7, 9 with `out_ready_i`=1: each appears 1 cycle after acceptance in order, and `in_ready_o` stays 1.
- Hold `out_ready_i`=0 and offer 2 payloads: `in_ready_o`=0 from the third cycle onward. Release ready: A then B emerge on consecutive cycles with no loss.
- Branch cases:
  - BEQ, `alu_zero_i`=1, target 0x100: `redirect_o` pulses for 1 cycle with `redirect_pc_o`=0x100.
  - BGE (101) with zero=0: no redirect.
  - BLTU (110) with zero=0: redirect.
- Skid full, then `flush_i`=1 together with an offered taken branch: next cycle `out_valid_o`=0, `in_ready_o`=1 and no redirect.
- Assert `rst_i` asynchronously between clock edges while holding 2 entries: outputs go to their reset values immediately, before the next clock edge.
- With `EX_MEM_FWD_EN`: an entry with rd=x5, reg_write=1 and result 0x2A gives `fwd_valid_o`=1, `fwd_rd_o`=5 and `fwd_data_o`=0x2A. With rd=x0, `fwd_valid_o`=0.
